// File: rtl/crc5_usb_pkg.sv
// Shared constants, FSM encoding and CRC-5/USB bit step for the transmitter/receiver pair.
package crc5_usb_pkg;
  localparam int MSG_W   = 11;
  localparam int CRC_W   = 5;
  localparam int FRAME_W = MSG_W + CRC_W;

  localparam logic [CRC_W-1:0] CRC5_POLY     = 5'b00101;
  localparam logic [CRC_W-1:0] CRC5_INIT     = 5'b11111;
  localparam logic [CRC_W-1:0] CRC5_RESIDUAL = 5'b01100;

  typedef enum logic [1:0] {
    ST_CAPTURE,
    ST_TRANSMIT,
    ST_HALT
  } state_e;

  function automatic logic [CRC_W-1:0] crc5_step(
    input logic [CRC_W-1:0] crc,
    input logic             b,
    input logic [CRC_W-1:0] poly = CRC5_POLY
  );
    logic fb;
    fb = b ^ crc[CRC_W-1];
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);
  endfunction
endpackage

// File: rtl/crc5_lfsr.sv
// Serial CRC-5 register: preset on reset/clear, advances one message bit per enabled clock.
module crc5_lfsr
  import crc5_usb_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = CRC5_POLY,
  parameter logic [CRC_W-1:0] INIT = CRC5_INIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_bit,
  output logic [CRC_W-1:0] o_crc
);
  logic [CRC_W-1:0] r_crc;

  always_ff @(posedge clk) begin
    if (rst || i_clr)
      r_crc <= INIT;
    else if (i_en)
      r_crc <= crc5_step(r_crc, i_bit, POLY);
  end

  assign o_crc = r_crc;
endmodule

// File: rtl/crc_transmitter.sv
// Captures an 11-bit serial message, then emits message + inverted CRC-5 (MSB first) once per reset.
// Optional CRC_TX_NRZI_EN: send carries the frame NRZI-encoded (0 toggles the line, 1 holds it).
module crc_transmitter
  import crc5_usb_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = CRC5_POLY,
  parameter logic [CRC_W-1:0] INIT = CRC5_INIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  output logic             send,
  output logic             done,
  output logic             OK,
  output logic [MSG_W-1:0] msg
);
  localparam int CNT_W = $clog2(FRAME_W);

  state_e             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [MSG_W-1:0]   r_msg, w_msg_nxt;
  logic [FRAME_W-1:0] r_frame, w_frame;
  logic [CRC_W-1:0]   w_crc, w_crc_fin;
  logic               r_send, r_done, r_ok;
  logic               w_cap, w_last_cap, w_last_tx;
  logic               w_bit, w_bit_vld;

  assign w_cap      = (r_state == ST_CAPTURE);
  assign w_last_cap = w_cap && (r_cnt == CNT_W'(MSG_W - 1));
  assign w_last_tx  = (r_state == ST_TRANSMIT) && (r_cnt == CNT_W'(FRAME_W - 1));

  crc5_lfsr #(.POLY(POLY), .INIT(INIT)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .i_clr (1'b0),
    .i_en  (w_cap),
    .i_bit (in),
    .o_crc (w_crc)
  );

  // The frame is latched on the last capture edge, so fold in bit 10 combinationally.
  assign w_crc_fin = crc5_step(w_crc, in, POLY);

  always_comb begin
    w_msg_nxt = r_msg;
    if (w_cap)
      w_msg_nxt[r_cnt] = in;
  end

  always_comb begin
    w_frame = '0;
    w_frame[MSG_W-1:0] = w_msg_nxt;
    for (int j = 0; j < CRC_W; j++)
      w_frame[MSG_W+j] = ~w_crc_fin[CRC_W-1-j];
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CAPTURE:  if (w_last_cap) w_state_nxt = ST_TRANSMIT;
      ST_TRANSMIT: if (w_last_tx)  w_state_nxt = ST_HALT;
      ST_HALT:     w_state_nxt = ST_HALT;
      default:     w_state_nxt = ST_CAPTURE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_CAPTURE;
    else     r_state <= w_state_nxt;
  end

  // Next data bit to place on the line: frame[0] on the last capture edge, then frame[cnt+1].
  always_comb begin
    w_bit_vld = 1'b0;
    w_bit     = 1'b0;
    if (w_last_cap) begin
      w_bit_vld = 1'b1;
      w_bit     = w_frame[0];
    end else if ((r_state == ST_TRANSMIT) && !w_last_tx) begin
      w_bit_vld = 1'b1;
      w_bit     = r_frame[r_cnt + 1'b1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_msg   <= '0;
      r_frame <= '0;
      r_done  <= 1'b0;
      r_ok    <= 1'b0;
`ifdef CRC_TX_NRZI_EN
      r_send  <= 1'b1;
`else
      r_send  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_CAPTURE: begin
          r_msg <= w_msg_nxt;
          if (w_last_cap) begin
            r_cnt   <= '0;
            r_frame <= w_frame;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_TRANSMIT: begin
          if (w_last_tx) begin
            r_cnt  <= '0;
            r_done <= 1'b1;
            r_ok   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
`ifdef CRC_TX_NRZI_EN
      if (w_bit_vld)
        r_send <= w_bit ? r_send : ~r_send;
`else
      r_send <= w_bit_vld & w_bit;
`endif
    end
  end

  assign send = r_send;
  assign done = r_done;
  assign OK   = r_ok;
  assign msg  = r_msg;
endmodule

// File: tb/tb_crc_transmitter.sv
// Self-checking bench for crc_transmitter: fixed USB vectors plus random messages against a CRC model.
module tb_crc_transmitter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in  = 1'b0;
  logic        send, done, OK;
  logic [10:0] msg;

  int   vecs = 0;
  int   errs = 0;
  logic exp_level;

`ifdef CRC_TX_NRZI_EN
  localparam logic IDLE = 1'b1;
`else
  localparam logic IDLE = 1'b0;
`endif

  localparam logic [10:0] MAIN_MSG   = 11'h53A;
  localparam logic [15:0] MAIN_FRAME = 16'h3D3A;
  localparam logic [15:0] ZERO_FRAME = 16'h1000;

  always #5 clk = ~clk;

  crc_transmitter dut (
    .clk  (clk),
    .rst  (rst),
    .in   (in),
    .send (send),
    .done (done),
    .OK   (OK),
    .msg  (msg)
  );

  // Reference: CRC-5/USB by long-hand bit division, frame = message then inverted CRC MSB first.
  function automatic logic [15:0] ref_frame(input logic [10:0] m);
    int          crc;
    int          fb;
    logic [15:0] f;
    crc = 31;
    for (int i = 0; i < 11; i++) begin
      fb  = int'(m[i]) ^ ((crc >> 4) & 1);
      crc = ((crc << 1) & 31) ^ (fb != 0 ? 5 : 0);
    end
    f[10:0] = m;
    for (int j = 0; j < 5; j++)
      f[11+j] = (((crc >> (4 - j)) & 1) == 0);
    return f;
  endfunction

  // Expected line level carrying data bit b.
  function automatic logic line_for(input logic b);
`ifdef CRC_TX_NRZI_EN
    if (!b) exp_level = ~exp_level;
    return exp_level;
`else
    return b;
`endif
  endfunction

  function automatic logic halt_level();
`ifdef CRC_TX_NRZI_EN
    return exp_level;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in  = 1'($urandom);
    step();
    step();
    rst = 1'b0;
    exp_level = IDLE;
  endtask

  // Captures m, then checks the 16 line cycles, done pulse and HALT entry. abort_at<16 resets at that bit.
  task automatic run_frame(input logic [10:0] m, input logic [15:0] f, input string tag, input int abort_at);
    logic e;
    for (int i = 0; i < 11; i++) begin
      in = m[i];
      vecs++;
      if (done !== 1'b0 || OK !== 1'b0) begin
        errs++;
        $display("FAIL %s capture i=%0d done=%b OK=%b want 0 0", tag, i, done, OK);
      end
      step();
    end
    for (int k = 0; k < 16; k++) begin
      in = 1'($urandom);
      e  = line_for(f[k]);
      vecs++;
      if (send !== e || done !== 1'b0) begin
        errs++;
        $display("FAIL %s bit k=%0d send=%b want %b done=%b", tag, k, send, e, done);
      end
      if (k == abort_at) begin
        rst = 1'b1;
        step();
        vecs++;
        if (send !== IDLE || done !== 1'b0 || OK !== 1'b0 || msg !== 11'h0) begin
          errs++;
          $display("FAIL %s abort send=%b done=%b OK=%b msg=%h want %b 0 0 000", tag, send, done, OK, msg, IDLE);
        end
        rst = 1'b0;
        exp_level = IDLE;
        return;
      end
      step();
    end
    vecs++;
    if (done !== 1'b1 || OK !== 1'b1 || msg !== m || send !== halt_level()) begin
      errs++;
      $display("FAIL %s halt done=%b OK=%b msg=%h send=%b want 1 1 %h %b", tag, done, OK, msg, send, m, halt_level());
    end
    step();
    vecs++;
    if (done !== 1'b0 || OK !== 1'b1) begin
      errs++;
      $display("FAIL %s post done=%b OK=%b want 0 1", tag, done, OK);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    vecs++;
    if (send !== IDLE || done !== 1'b0 || OK !== 1'b0 || msg !== 11'h0) begin
      errs++;
      $display("FAIL reset send=%b done=%b OK=%b msg=%h want %b 0 0 000", send, done, OK, msg, IDLE);
    end
  endtask

  task automatic test_main();
    do_reset();
    run_frame(MAIN_MSG, MAIN_FRAME, "main", 16);
  endtask

  task automatic test_all_zero();
    do_reset();
    run_frame(11'h000, ZERO_FRAME, "zero", 16);
  endtask

  task automatic test_reset_mid_capture();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      in = 1'($urandom);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vecs++;
    if (msg !== 11'h0 || done !== 1'b0 || OK !== 1'b0) begin
      errs++;
      $display("FAIL midcap_reset msg=%h done=%b OK=%b want 000 0 0", msg, done, OK);
    end
    exp_level = IDLE;
    run_frame(MAIN_MSG, MAIN_FRAME, "midcap", 16);
  endtask

  task automatic test_reset_mid_tx();
    logic [10:0] m;
    do_reset();
    m = 11'($urandom);
    run_frame(m, ref_frame(m), "midtx_abort", 7);
    m = 11'($urandom);
    run_frame(m, ref_frame(m), "midtx_fresh", 16);
  endtask

  task automatic test_halt_stable();
    logic [10:0] m;
    logic        h;
    do_reset();
    m = 11'($urandom);
    run_frame(m, ref_frame(m), "halt_frame", 16);
    h = halt_level();
    for (int c = 0; c < 20; c++) begin
      in = c[0];
      step();
      vecs++;
      if (send !== h || OK !== 1'b1 || done !== 1'b0 || msg !== m) begin
        errs++;
        $display("FAIL halt_stable c=%0d send=%b OK=%b done=%b msg=%h want %b 1 0 %h", c, send, OK, done, msg, h, m);
      end
    end
  endtask

  task automatic test_random();
    logic [10:0] m;
    for (int n = 0; n < 6; n++) begin
      do_reset();
      m = 11'($urandom);
      run_frame(m, ref_frame(m), "random", 16);
    end
  endtask

  initial begin
    test_reset();
    test_main();
    test_all_zero();
    test_reset_mid_capture();
    test_reset_mid_tx();
    test_halt_stable();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
